// File: rtl/tf_index_sequencer.sv
// Twiddle-factor index sequencer: walks five NTT/INTT stages and emits one (k, p) pair
// per butterfly cycle, with stall support and a programmable inter-stage drain gap.
module tf_index_sequencer #(
    parameter int unsigned STAGE_GAP     = 2,
    parameter int unsigned CYC_PER_STAGE = 128
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] conf_in,
    input  logic       hold,
    output logic [2:0] conf,
    output logic [6:0] k,
    output logic [9:0] p,
    output logic       valid,
    output logic       busy,
    output logic       done
);

    localparam logic [6:0] CLast   = 7'(CYC_PER_STAGE - 1);
    localparam logic [3:0] GapLast = (STAGE_GAP == 0) ? 4'd0 : 4'(STAGE_GAP - 1);

    typedef enum logic [1:0] {StIdle, StRun, StGap, StDone} state_e;

    state_e     state_q, state_d;
    logic [6:0] c_q, c_d;
    logic [3:0] gap_q, gap_d;
    logic [2:0] stage_q, stage_d;
    logic [2:0] conf_q, conf_d;
    logic [6:0] k_q, k_d;
    logic [2:0] p_q, p_d;
    logic       valid_q, valid_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [2:0] cur_p;

    function automatic logic is_ntt(input logic [2:0] cf);
        return (cf == 3'b001) || (cf == 3'b100);
    endfunction

    // Stage counter always runs 0..4; NTT order reverses it into p = 4..0.
    function automatic logic [2:0] stage_p(input logic [2:0] st, input logic ntt);
        return ntt ? (3'd4 - st) : st;
    endfunction

    function automatic logic [6:0] k_of(input logic [6:0] cyc, input logic [2:0] pp);
        case (pp)
            3'd0:    return cyc;
            3'd1:    return cyc >> 1;
            3'd2:    return cyc >> 3;
            3'd3:    return cyc >> 5;
            default: return 7'd0;
        endcase
    endfunction

    assign cur_p = stage_p(stage_q, is_ntt(conf_q));

    // Outputs are registered one cycle behind the (state, c) they describe.
    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        gap_d   = gap_q;
        stage_d = stage_q;
        conf_d  = conf_q;
        k_d     = k_q;
        p_d     = p_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        if (!hold) begin
            unique case (state_q)
                StIdle: begin
                    k_d    = 7'd0;
                    p_d    = 3'd0;
                    busy_d = 1'b0;
                    if (start) begin
                        state_d = StRun;
                        conf_d  = conf_in;
                        stage_d = 3'd0;
                        c_d     = 7'd0;
                        gap_d   = 4'd0;
                        busy_d  = 1'b1;
                        p_d     = stage_p(3'd0, is_ntt(conf_in));
                    end
                end
                StRun: begin
                    valid_d = 1'b1;
                    p_d     = cur_p;
                    k_d     = k_of(c_q, cur_p);
                    c_d     = c_q + 7'd1;
                    if (c_q == CLast) begin
                        c_d   = 7'd0;
                        gap_d = 4'd0;
                        if (stage_q == 3'd4) begin
                            state_d = StDone;
                        end else begin
                            stage_d = stage_q + 3'd1;
                            state_d = (STAGE_GAP == 0) ? StRun : StGap;
                        end
                    end
                end
                StGap: begin
                    if (gap_q == GapLast) begin
                        state_d = StRun;
                    end else begin
                        gap_d = gap_q + 4'd1;
                    end
                end
                StDone: begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    stage_d = 3'd0;
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            c_q     <= 7'd0;
            gap_q   <= 4'd0;
            stage_q <= 3'd0;
            conf_q  <= 3'd0;
            k_q     <= 7'd0;
            p_q     <= 3'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            gap_q   <= gap_d;
            stage_q <= stage_d;
            conf_q  <= conf_d;
            k_q     <= k_d;
            p_q     <= p_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign conf  = conf_q;
    assign k     = k_q;
    assign p     = {7'd0, p_q};
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
